// File: rtl/alu_sequencer.sv
// Shares one 8-bit ALU slice between 16-bit two-pass operations and an 8x8 shift-add multiply.
// Takes one request at a time through start/done and returns a 16-bit result with zero/carry flags.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter logic [2:0] ADD_CODE = 3'd0,
  parameter logic [2:0] MUL_CODE = 3'd6
) (
  input  logic        workClk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opt,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        co,
  output logic [2:0]  aluOpt,
  output logic [7:0]  aluNumA,
  output logic [7:0]  aluNumB,
  output logic        aluCi,
  input  logic [7:0]  aluS,
  input  logic        aluZero,
  input  logic        aluCo
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StMlo, StMhi, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;
  logic        ct_q, ct_d;
  logic        z1_q, z1_d;
  logic [15:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        co_q, co_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    ct_d     = ct_q;
    z1_d     = z1_q;
    result_d = result_q;
    zero_d   = zero_q;
    co_d     = co_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (opt == MUL_CODE) begin
            mcand_d  = {8'h00, opA[7:0]};
            mplier_d = opB[7:0];
            acc_d    = 16'h0000;
            cnt_d    = 3'd0;
            state_d  = StMlo;
          end else begin
            a_d     = opA;
            b_d     = opB;
            op_d    = opt;
            state_d = StLo;
          end
        end
      end
      StLo: begin
        lo_d    = aluS;
        ct_d    = aluCo;
        z1_d    = aluZero;
        state_d = StHi;
      end
      StHi: begin
        result_d = {aluS, lo_q};
        zero_d   = z1_q & aluZero;
        co_d     = aluCo;
        state_d  = StDone;
      end
      StMlo: begin
        acc_d[7:0] = aluS;
        ct_d       = aluCo;
        z1_d       = aluZero;
        state_d    = StMhi;
      end
      StMhi: begin
        acc_d[15:8] = aluS;
        mcand_d     = {mcand_q[14:0], 1'b0};
        mplier_d    = {1'b0, mplier_q[7:1]};
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Product width fits 16 bits, so the final carry is always zero.
          result_d = {aluS, acc_q[7:0]};
          zero_d   = z1_q & aluZero;
          co_d     = 1'b0;
          state_d  = StDone;
        end else begin
          state_d = StMlo;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge workClk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      ct_q     <= 1'b0;
      z1_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      co_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      ct_q     <= ct_d;
      z1_q     <= z1_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      co_q     <= co_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ALU drives decode straight from the registered state: the ALU answers within the same cycle.
  always_comb begin
    aluOpt  = 3'd0;
    aluNumA = 8'h00;
    aluNumB = 8'h00;
    aluCi   = 1'b0;
    unique case (state_q)
      StLo: begin
        aluOpt  = op_q;
        aluNumA = a_q[7:0];
        aluNumB = b_q[7:0];
      end
      StHi: begin
        aluOpt  = op_q;
        aluNumA = a_q[15:8];
        aluNumB = b_q[15:8];
        aluCi   = ct_q;
      end
      StMlo: begin
        aluOpt  = ADD_CODE;
        aluNumA = acc_q[7:0];
        aluNumB = mplier_q[0] ? mcand_q[7:0] : 8'h00;
      end
      StMhi: begin
        aluOpt  = ADD_CODE;
        aluNumA = acc_q[15:8];
        aluNumB = mplier_q[0] ? mcand_q[15:8] : 8'h00;
        aluCi   = ct_q;
      end
      default: ;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign co     = co_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU and a result scoreboard.
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic        workClk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opt;
  logic [15:0] opA, opB;
  logic        busy, done, zero, co;
  logic [15:0] result;
  logic [2:0]  aluOpt;
  logic [7:0]  aluNumA, aluNumB;
  logic        aluCi;
  logic [7:0]  aluS;
  logic        aluZero, aluCo;
  logic [8:0]  sum9;

  typedef struct packed {
    logic [15:0] r;
    logic        z;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 workClk = ~workClk;

  // ALU model: opcode 0 is add with carry-in, any other opcode is a bytewise XOR.
  always_comb begin
    if (aluOpt == 3'd0) sum9 = {1'b0, aluNumA} + {1'b0, aluNumB} + {8'h00, aluCi};
    else                sum9 = {1'b0, aluNumA ^ aluNumB};
    aluS    = sum9[7:0];
    aluCo   = sum9[8];
    aluZero = (sum9[7:0] == 8'h00);
  end

  alu_sequencer dut (
    .workClk (workClk),
    .reset   (reset),
    .start   (start),
    .opt     (opt),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .zero    (zero),
    .co      (co),
    .aluOpt  (aluOpt),
    .aluNumA (aluNumA),
    .aluNumB (aluNumB),
    .aluCi   (aluCi),
    .aluS    (aluS),
    .aluZero (aluZero),
    .aluCo   (aluCo)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [16:0] s;
    if (op == 3'd6) begin
      e.r = {8'h00, a[7:0]} * {8'h00, b[7:0]};
      e.c = 1'b0;
    end else if (op == 3'd0) begin
      s   = {1'b0, a} + {1'b0, b};
      e.r = s[15:0];
      e.c = s[16];
    end else begin
      e.r = a ^ b;
      e.c = 1'b0;
    end
    e.z = (e.r == 16'h0000);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge workClk);
    #1;
  endtask

  // Issues one request and follows it to its done pulse, counting edges from the accepting edge.
  task automatic run_req(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input bit inject, input int exp_edges,
                         output logic ci_lo, output logic ci_hi, output bit opt_bad);
    exp_t e;
    int   n;
    int   busy_n;
    sb.push_back(model(op, a, b));
    opt = op; opA = a; opB = b; start = 1'b1;
    n = 0; busy_n = 0; opt_bad = 1'b0; ci_lo = 1'bx; ci_hi = 1'bx;
    do begin
      tick();
      n++;
      start = 1'b0;
      opA   = 16'hDEAD;
      opB   = 16'hBEEF;
      if (inject && (n == 2 || n == 3)) begin
        start = 1'b1; opt = 3'd0; opA = 16'h0005; opB = 16'h0005;
      end
      if (busy) busy_n++;
      if (n == 1) ci_lo = aluCi;
      if (n == 2) ci_hi = aluCi;
      if (op == 3'd6 && busy && !done && aluOpt !== 3'd0) opt_bad = 1'b1;
    end while (!done && n < 40);
    check({tag, " done_edges"}, n, exp_edges);
    check({tag, " busy_cycles"}, busy_n, exp_edges);
    if (sb.size() == 0) begin
      check({tag, " scoreboard_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, " result"}, result, e.r);
      check({tag, " zero"}, zero, e.z);
      check({tag, " co"}, co, e.c);
    end
    tick();
    start = 1'b0;
    check({tag, " done_single_pulse"}, done, 1'b0);
    tick();
    check({tag, " idle_after"}, busy, 1'b0);
  endtask

  initial begin
    logic ci_lo, ci_hi;
    bit   opt_bad;
    bit   saw_done;
    int   n;

    reset = 1'b0; start = 1'b0; opt = 3'd0; opA = 16'h0; opB = 16'h0;
    tick();
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 16'h0000);
    check("reset flags", {zero, co}, 2'b00);
    check("reset alu drives", {aluOpt, aluNumA, aluNumB, aluCi}, 20'h0);
    tick();
    reset = 1'b1;
    tick();

    run_req("add01ff", 3'd0, 16'h01FF, 16'h0001, 1'b0, 3, ci_lo, ci_hi, opt_bad);
    check("add01ff lo_ci", ci_lo, 1'b0);
    check("add01ff hi_ci", ci_hi, 1'b1);

    run_req("addffff", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 3, ci_lo, ci_hi, opt_bad);

    run_req("mulff", 3'd6, 16'h12FF, 16'h34FF, 1'b0, 17, ci_lo, ci_hi, opt_bad);
    check("mulff alu_opt_add", opt_bad, 1'b0);

    run_req("mul0", 3'd6, 16'h0003, 16'hAB00, 1'b0, 17, ci_lo, ci_hi, opt_bad);

    run_req("op7", 3'd7, 16'h5AA5, 16'h0FF0, 1'b0, 3, ci_lo, ci_hi, opt_bad);

    run_req("ignore_start", 3'd0, 16'h1234, 16'h0100, 1'b1, 3, ci_lo, ci_hi, opt_bad);
    repeat (2) tick();
    check("ignore_start stays_idle", busy, 1'b0);
    check("ignore_start result_held", result, 16'h1334);

    // Multiply aborted by reset in its eighth cycle.
    opt = 3'd6; opA = 16'h00FF; opB = 16'h00FF; start = 1'b1;
    tick();
    start = 1'b0;
    for (n = 1; n < 8; n++) tick();
    check("abort busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort result", result, 16'h0000);
    check("abort done", done, 1'b0);
    check("abort alu drives", {aluOpt, aluNumA, aluNumB, aluCi}, 20'h0);
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (20) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("abort no_done", saw_done, 1'b0);

    run_req("add_after_reset", 3'd0, 16'h0002, 16'h0003, 1'b0, 3, ci_lo, ci_hi, opt_bad);
    check("add_after_reset value", result, 16'h0005);
    check("scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
